pack_alloc: RTL and testbench
=============================

PACK_ALLOC -- requirements
Module: pack_alloc

Interface
REQ-001 SHALL have parameter PACKS, default 16, number of instruction packs in flight (power of two).
REQ-002 SHALL have port cpu_clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port cpu_rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rn_valid_i  input  1  rename offers a pack.
REQ-005 SHALL have port rn_ready_o  output  1  block accepts the pack this cycle.
REQ-006 SHALL have port rn_ins0_valid_i / rn_ins1_valid_i  input  1 each  slot occupied.
REQ-007 SHALL have port rn_ins0_pkt_i / rn_ins1_pkt_i  input  52 each  {opcode[6:0], ins_type[5:0], imm, immediate[31:0], dest[5:0]}, MSB first.
REQ-008 SHALL have port ins0_valid_o / ins1_valid_o  output  1 each  instruction-RAM write strobe per slot.
REQ-009 SHALL have port ins0_pkt_o / ins1_pkt_o  output  52 each  write data, same field order.
REQ-010 SHALL have port pack_id_o  output  4  write address (pack index).
REQ-011 SHALL have port rob_base_o  output  5  {pack_id_o, 1'b0}, ROB id of slot 0; slot 1 is base+1.
REQ-012 SHALL have port commit_i  input  1  oldest pack retired, free it.
REQ-013 SHALL have port flush_i  input  1  discard all in-flight packs.
REQ-014 SHALL have port count_o  output  5  packs in flight, 0..16.
REQ-015 SHALL have port commit_err_o  output  1  sticky: commit seen while empty.

Function
REQ-016 Handshake SHALL be: accept = rn_valid_i & rn_ready_o & (rn_ins0_valid_i | rn_ins1_valid_i); a pack with both slots invalid SHALL be consumed without allocating.
REQ-017 rn_ready_o SHALL equal (count_o != PACKS) & ~flush_i; a same-cycle commit SHALL NOT open space (no bypass).
REQ-018 On accept at cycle N, outputs at N+1 SHALL be: pack_id_o = tail at N, insX_valid_o = rn_insX_valid_i at N, insX_pkt_o = captured payload; strobes SHALL be single-cycle.
REQ-019 Outputs SHALL be registered; ins*_valid_o SHALL be 0 in any cycle not following an accept.
REQ-020 Tail SHALL increment modulo PACKS on accept; head SHALL increment modulo PACKS on commit_i when count_o != 0.
REQ-021 count_o SHALL be +1 on accept only, -1 on valid commit only, unchanged on both together.
REQ-022 commit_i while count_o == 0 SHALL be ignored for pointers and SHALL set commit_err_o until reset.
REQ-023 flush_i SHALL, at the next edge, zero head, tail, count_o and ins*_valid_o, overriding same-cycle accept and commit.
REQ-024 pack_id_o and ins*_pkt_o SHALL hold their last value while strobes are low.

Reset
REQ-025 Asserting cpu_rstn_i low SHALL immediately clear head, tail, count_o, ins*_valid_o, commit_err_o, pack_id_o, rob_base_o and ins*_pkt_o to 0.
REQ-026 rn_ready_o SHALL be 1 on the first edge after release; a write in progress at reset SHALL be lost.

Structure
REQ-027 The 52-bit packet typedef, field widths and PACKS default SHALL live in the shared math-system package, used by this block and the instruction RAM.
REQ-028 A single sub-module, pack_ptr_ctr (modulo pointer with increment and clear), SHALL be instantiated for head and tail.

Verification
REQ-029 Reset, then one pack with both slots valid -> next cycle pack_id_o=0, rob_base_o=0, both strobes 1; count_o=1.
REQ-030 16 back-to-back packs, no commit -> pack_ids 0..15 in order, rn_ready_o=0 after the 16th, count_o=16; a 17th offer is held.
REQ-031 Full, then commit_i together with rn_valid_i -> no accept that cycle, count_o=15; accept next cycle, pack_id_o=0 (wrap).
REQ-032 Count 5, accept+commit same cycle -> count_o stays 5, tail+1, head+1.
REQ-033 Count 3, flush_i with rn_valid_i -> no strobe next cycle, count_o=0; next pack gets pack_id_o=0.
REQ-034 commit_i with count_o=0 -> count_o stays 0, commit_err_o=1 until reset; slot1-only pack -> ins0_valid_o=0, ins1_valid_o=1.

Source files
------------

// File: rtl/pack_alloc_pkg.sv
// Shared instruction-packet types and sizing for the pack allocator and the instruction RAM.
package pack_alloc_pkg;

    localparam int unsigned PACKS_DEF = 16;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned TYPE_W    = 6;
    localparam int unsigned IMM_W     = 32;
    localparam int unsigned DEST_W    = 6;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [TYPE_W-1:0] ins_type;
        logic              imm;
        logic [IMM_W-1:0]  immediate;
        logic [DEST_W-1:0] dest;
    } ins_pkt_t;

    localparam int unsigned PKT_W = $bits(ins_pkt_t);

endpackage

// File: rtl/pack_alloc_ptr_ctr.sv
// Modulo pointer with increment and synchronous clear; wraps naturally since DEPTH is a power of two.
module pack_ptr_ctr
    import pack_alloc_pkg::*;
#(
    parameter int unsigned DEPTH = PACKS_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic [$clog2(DEPTH)-1:0] ptr_o
);

    logic [$clog2(DEPTH)-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)      ptr_d = '0;
        else if (inc_i) ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pack_alloc.sv
// Allocates instruction-pack slots in a circular buffer and issues registered instruction-RAM writes.
module pack_alloc
    import pack_alloc_pkg::*;
#(
    parameter int unsigned PACKS = PACKS_DEF
) (
    input  logic                       cpu_clk_i,
    input  logic                       cpu_rstn_i,
    input  logic                       rn_valid_i,
    output logic                       rn_ready_o,
    input  logic                       rn_ins0_valid_i,
    input  logic                       rn_ins1_valid_i,
    input  logic [PKT_W-1:0]           rn_ins0_pkt_i,
    input  logic [PKT_W-1:0]           rn_ins1_pkt_i,
    output logic                       ins0_valid_o,
    output logic                       ins1_valid_o,
    output logic [PKT_W-1:0]           ins0_pkt_o,
    output logic [PKT_W-1:0]           ins1_pkt_o,
    output logic [$clog2(PACKS)-1:0]   pack_id_o,
    output logic [$clog2(PACKS):0]     rob_base_o,
    input  logic                       commit_i,
    input  logic                       flush_i,
    output logic [$clog2(PACKS):0]     count_o,
    output logic                       commit_err_o
);

    localparam int unsigned IW = $clog2(PACKS);
    localparam logic [IW:0] FULL = (IW+1)'(PACKS);

    logic [IW-1:0]    head_ptr, tail_ptr;
    logic [IW:0]      count_q, count_d;
    logic             v0_q, v0_d, v1_q, v1_d;
    logic [PKT_W-1:0] p0_q, p0_d, p1_q, p1_d;
    logic [IW-1:0]    id_q, id_d;
    logic             err_q, err_d;
    logic             accept, commit_ok;

    // Ready deliberately ignores commit_i: freeing a slot only takes effect next cycle.
    assign rn_ready_o = (count_q != FULL) & ~flush_i;
    assign accept     = rn_valid_i & rn_ready_o & (rn_ins0_valid_i | rn_ins1_valid_i);
    assign commit_ok  = commit_i & (count_q != '0) & ~flush_i;

    pack_ptr_ctr #(.DEPTH(PACKS)) u_head (
        .clk_i  (cpu_clk_i),
        .rst_ni (cpu_rstn_i),
        .clr_i  (flush_i),
        .inc_i  (commit_ok),
        .ptr_o  (head_ptr)
    );

    pack_ptr_ctr #(.DEPTH(PACKS)) u_tail (
        .clk_i  (cpu_clk_i),
        .rst_ni (cpu_rstn_i),
        .clr_i  (flush_i),
        .inc_i  (accept),
        .ptr_o  (tail_ptr)
    );

    always_comb begin
        count_d = count_q;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        p0_d    = p0_q;
        p1_d    = p1_q;
        id_d    = id_q;
        err_d   = err_q | (commit_i & (count_q == '0));
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (accept && !commit_ok)      count_d = count_q + 1'b1;
            else if (!accept && commit_ok) count_d = count_q - 1'b1;
            if (accept) begin
                v0_d = rn_ins0_valid_i;
                v1_d = rn_ins1_valid_i;
                p0_d = rn_ins0_pkt_i;
                p1_d = rn_ins1_pkt_i;
                id_d = tail_ptr;
            end
        end
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            count_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            p0_q    <= '0;
            p1_q    <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign ins0_valid_o = v0_q;
    assign ins1_valid_o = v1_q;
    assign ins0_pkt_o   = p0_q;
    assign ins1_pkt_o   = p1_q;
    assign pack_id_o    = id_q;
    assign rob_base_o   = {id_q, 1'b0};
    assign count_o      = count_q;
    assign commit_err_o = err_q;

    // Occupancy must always match the pointer distance (modulo PACKS).
    ptr_consistent: assert property (@(posedge cpu_clk_i) disable iff (!cpu_rstn_i)
        IW'(tail_ptr - head_ptr) == count_q[IW-1:0]);

endmodule

// File: tb/tb_pack_alloc.sv
// Randomized and directed bench for pack_alloc against a queue-based occupancy model.
module tb_pack_alloc;

    localparam int unsigned PACKS = 16;
    localparam int unsigned PW    = 52;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rn_valid, rn_ready, i0v, i1v;
    logic [PW-1:0] i0p, i1p;
    logic          o0v, o1v;
    logic [PW-1:0] o0p, o1p;
    logic [3:0]    pack_id;
    logic [4:0]    rob_base;
    logic          commit, flush;
    logic [4:0]    count;
    logic          cerr;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Model: queue of pack ids in flight, next id to hand out, expected output registers.
    int unsigned   inflight[$];
    int unsigned   next_id;
    bit            m_err;
    bit            e_v0, e_v1;
    logic [PW-1:0] e_p0, e_p1;
    int unsigned   e_id;

    always #5 clk = ~clk;

    pack_alloc #(.PACKS(PACKS)) dut (
        .cpu_clk_i       (clk),
        .cpu_rstn_i      (rstn),
        .rn_valid_i      (rn_valid),
        .rn_ready_o      (rn_ready),
        .rn_ins0_valid_i (i0v),
        .rn_ins1_valid_i (i1v),
        .rn_ins0_pkt_i   (i0p),
        .rn_ins1_pkt_i   (i1p),
        .ins0_valid_o    (o0v),
        .ins1_valid_o    (o1v),
        .ins0_pkt_o      (o0p),
        .ins1_pkt_o      (o1p),
        .pack_id_o       (pack_id),
        .rob_base_o      (rob_base),
        .commit_i        (commit),
        .flush_i         (flush),
        .count_o         (count),
        .commit_err_o    (cerr)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PW-1:0];
    endfunction

    task automatic check_outputs(input string ctx);
        check({ctx, ".count"},    64'(count),    64'(inflight.size()));
        check({ctx, ".v0"},       64'(o0v),      64'(e_v0));
        check({ctx, ".v1"},       64'(o1v),      64'(e_v1));
        check({ctx, ".pack_id"},  64'(pack_id),  64'(e_id));
        check({ctx, ".rob_base"}, 64'(rob_base), 64'(e_id * 2));
        check({ctx, ".pkt0"},     64'(o0p),      64'(e_p0));
        check({ctx, ".pkt1"},     64'(o1p),      64'(e_p1));
        check({ctx, ".err"},      64'(cerr),     64'(m_err));
    endtask

    task automatic model_reset();
        inflight.delete();
        next_id = 0;
        m_err   = 0;
        e_v0 = 0; e_v1 = 0; e_id = 0;
        e_p0 = '0; e_p1 = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        rn_valid = 0; i0v = 0; i1v = 0; commit = 0; flush = 0;
        #2 rstn = 0;
        model_reset();
        #1 check_outputs("reset");
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic step(input bit v, input bit a0, input bit a1, input bit c, input bit f);
        bit            acc;
        bit            exp_rdy;
        logic [PW-1:0] p0, p1;
        p0 = rnd_pkt();
        p1 = rnd_pkt();
        @(negedge clk);
        rn_valid = v; i0v = a0; i1v = a1; i0p = p0; i1p = p1; commit = c; flush = f;
        #1;
        exp_rdy = (inflight.size() != PACKS) && !f;
        check("ready", 64'(rn_ready), 64'(exp_rdy));
        acc = v && exp_rdy && (a0 || a1);
        e_v0 = 0; e_v1 = 0;
        if (c && inflight.size() == 0) m_err = 1;
        if (f) begin
            inflight.delete();
            next_id = 0;
        end else begin
            if (c && inflight.size() != 0) void'(inflight.pop_front());
            if (acc) begin
                inflight.push_back(next_id);
                e_id = next_id;
                next_id = (next_id + 1) % PACKS;
                e_v0 = a0; e_v1 = a1;
                e_p0 = p0; e_p1 = p1;
            end
        end
        @(posedge clk);
        #1 check_outputs("cycle");
    endtask

    initial begin
        rstn = 0; rn_valid = 0; i0v = 0; i1v = 0; i0p = '0; i1p = '0; commit = 0; flush = 0;
        model_reset();
        #1 check_outputs("por");
        repeat (2) @(negedge clk);
        rstn = 1;

        // Single full pack from reset.
        step(1, 1, 1, 0, 0);
        check("first.id", 64'(pack_id), 64'd0);
        check("first.count", 64'(count), 64'd1);
        step(0, 0, 0, 0, 0);

        // Fill to capacity, offer a 17th, then commit alongside an offer, then wrap.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 1, 1, 0, 0);
        check("full.count", 64'(count), 64'd16);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        check("full.commit", 64'(count), 64'd15);
        step(1, 1, 1, 0, 0);
        check("wrap.id", 64'(pack_id), 64'd0);

        // Accept and commit together at count 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        check("both.count", 64'(count), 64'd5);
        step(0, 0, 0, 1, 0);

        // Flush with a concurrent offer, then restart from id 0.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 0);
        check("flush.id", 64'(pack_id), 64'd0);

        // Commit while empty, empty pack, slot1-only pack.
        do_reset();
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check("slot1.v0", 64'(o0v), 64'd0);
        check("slot1.err", 64'(cerr), 64'd1);

        // Random traffic with occasional flush and one mid-run reset.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit f;
            f = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 f ? 1'b0 : ($urandom_range(0, 2) == 0), f);
            if (i == 750) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
